// File: rtl/clkdiv_scheduler.sv
// Round-robin owner of a shared frequency divider: arbitrates, loads N,
// releases the divider for a burst of clk_out toggles, then parks it in reset.
module clkdiv_scheduler #(
   parameter int NUM_REQ = 4,
   parameter int DIV_W   = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*DIV_W-1:0] req_div,
   input  logic [NUM_REQ*DIV_W-1:0] req_tog,
   input  logic                     div_clk_in,
   output logic [DIV_W-1:0]         div_n,
   output logic                     div_rst,
   output logic [NUM_REQ-1:0]       grant,
   output logic                     busy,
   output logic                     done,
   output logic                     abort,
   output logic                     err
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW = IW + 1;

   typedef enum logic [2:0] {
      IDLE,
      ARB,
      LOAD,
      RUN,
      RELEASE
   } state_t;

   state_t state_q, state_d;

   logic [IW-1:0]      ptr_q, ptr_d;
   logic [IW-1:0]      win_q, win_d;
   logic [IW-1:0]      arb_idx;
   logic               arb_found;
   logic [CW-1:0]      cand;
   logic [DIV_W-1:0]   sel_div, sel_tog;
   logic [DIV_W-1:0]   ratio_q, ratio_d;
   logic [DIV_W-1:0]   tog_q, tog_d;
   logic [DIV_W-1:0]   cnt_q, cnt_d;
   logic [DIV_W:0]     cnt_inc;
   logic [DIV_W-1:0]   div_n_d;
   logic               div_clk_q, div_clk_d;
   logic               tog_seen;
   logic               div_rst_d, busy_d, done_d, abort_d, err_d;
   logic [NUM_REQ-1:0] grant_d;

   // Search starts one past the last owner and wraps around.
   always_comb begin
      arb_found = 1'b0;
      arb_idx   = '0;
      cand      = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = {1'b0, ptr_q} + CW'(i);
         if (cand >= CW'(NUM_REQ))
            cand = cand - CW'(NUM_REQ);
         if (!arb_found && req[cand[IW-1:0]]) begin
            arb_found = 1'b1;
            arb_idx   = cand[IW-1:0];
         end
      end
      sel_div = req_div[arb_idx*DIV_W +: DIV_W];
      sel_tog = req_tog[arb_idx*DIV_W +: DIV_W];
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      win_d     = win_q;
      ratio_d   = ratio_q;
      tog_d     = tog_q;
      cnt_d     = cnt_q;
      div_n_d   = div_n;
      div_clk_d = div_clk_in;
      done_d    = 1'b0;
      abort_d   = 1'b0;
      err_d     = 1'b0;
      tog_seen  = 1'b0;
      cnt_inc   = {1'b0, cnt_q} + 1'b1;
      grant_d   = '0;

      unique case (state_q)
         IDLE: begin
            if (|req)
               state_d = ARB;
         end
         ARB: begin
            if (!arb_found) begin
               state_d = IDLE;
            end else begin
               win_d   = arb_idx;
               ratio_d = sel_div;
               tog_d   = sel_tog;
               if (sel_div == '0 || sel_tog == '0) begin
                  err_d   = 1'b1;
                  ptr_d   = arb_idx;
                  state_d = IDLE;
               end else begin
                  state_d = LOAD;
               end
            end
         end
         LOAD: begin
            state_d = RUN;
         end
         RUN: begin
            tog_seen = div_clk_in ^ div_clk_q;
            if (tog_seen)
               cnt_d = cnt_inc[DIV_W-1:0];
            // A dropped request ends the burst even on its final toggle.
            if (!req[win_q]) begin
               state_d = RELEASE;
               done_d  = 1'b1;
               abort_d = 1'b1;
            end else if (tog_seen && cnt_inc == {1'b0, tog_q}) begin
               state_d = RELEASE;
               done_d  = 1'b1;
            end
         end
         RELEASE: begin
            ptr_d   = win_q;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Outputs are registered against the state being entered.
      if (state_d == LOAD) begin
         div_n_d   = ratio_d;
         cnt_d     = '0;
         div_clk_d = 1'b0;
      end
      if (state_d == LOAD || state_d == RUN)
         grant_d[win_d] = 1'b1;
      div_rst_d = (state_d != RUN);
      busy_d    = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         ptr_q     <= IW'(NUM_REQ - 1);
         win_q     <= '0;
         ratio_q   <= '0;
         tog_q     <= '0;
         cnt_q     <= '0;
         div_clk_q <= 1'b0;
         div_n     <= '0;
         div_rst   <= 1'b1;
         grant     <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         abort     <= 1'b0;
         err       <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         win_q     <= win_d;
         ratio_q   <= ratio_d;
         tog_q     <= tog_d;
         cnt_q     <= cnt_d;
         div_clk_q <= div_clk_d;
         div_n     <= div_n_d;
         div_rst   <= div_rst_d;
         grant     <= grant_d;
         busy      <= busy_d;
         done      <= done_d;
         abort     <= abort_d;
         err       <= err_d;
      end
   end

endmodule

// File: tb/tb_clkdiv_scheduler.sv
// Directed bench for clkdiv_scheduler with a behavioural divider on div_clk_in.
module tb_clkdiv_scheduler;

   localparam int NR = 4;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic [NR-1:0] req;
   logic [NR*DW-1:0] req_div, req_tog;
   logic          div_clk_in;
   logic [DW-1:0] div_n;
   logic          div_rst;
   logic [NR-1:0] grant;
   logic          busy, done, abort, err;

   clkdiv_scheduler #(.NUM_REQ(NR), .DIV_W(DW)) dut (
      .clk(clk), .reset(reset), .req(req),
      .req_div(req_div), .req_tog(req_tog),
      .div_clk_in(div_clk_in), .div_n(div_n),
      .div_rst(div_rst), .grant(grant), .busy(busy),
      .done(done), .abort(abort), .err(err)
   );

   always #5 clk = ~clk;

   // Divider: clk_out toggles every N enabled cycles, cleared in reset.
   logic [DW-1:0] dcnt;
   logic          dout;
   assign div_clk_in = dout;
   always @(posedge clk) begin
      if (div_rst) begin
         dcnt <= '0;
         dout <= 1'b0;
      end else if (dcnt == DW'(div_n - 8'd1)) begin
         dcnt <= '0;
         dout <= ~dout;
      end else begin
         dcnt <= dcnt + 8'd1;
      end
   end

   int vec = 0;
   int miss = 0;

   int dcyc, gcnt, rcnt, togs, multi;
   int tc [0:7];
   logic dabort;
   logic [NR-1:0] dgrant;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_cfg(input int i, input int n, input int t);
      req_div[i*DW +: DW] = DW'(n);
      req_tog[i*DW +: DW] = DW'(t);
   endtask

   task automatic do_reset;
      reset = 1'b1;
      req   = '0;
      tick;
      tick;
      reset = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      logic prev;
      dcyc = -1; gcnt = 0; rcnt = 0; togs = 0; multi = 0;
      dabort = 1'bx; dgrant = 'x;
      prev = div_clk_in;
      for (int c = 0; c < budget; c++) begin
         tick;
         if (done) begin
            dcyc = c; dabort = abort; dgrant = grant;
            break;
         end
         if (grant != '0) gcnt++;
         if (!div_rst) rcnt++;
         if ($countones(grant) > 1) multi++;
         if (div_clk_in !== prev) begin
            if (togs < 8) tc[togs] = c;
            togs++;
         end
         prev = div_clk_in;
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; req = '0; req_div = '0; req_tog = '0;
      tick; tick;
      vec++; if (div_n !== 8'd0) begin miss++; $display("FAIL rst_div_n got %0d want 0", div_n); end
      vec++; if (div_rst !== 1'b1) begin miss++; $display("FAIL rst_div_rst got %b want 1", div_rst); end
      vec++; if (grant !== 4'b0) begin miss++; $display("FAIL rst_grant got %b want 0000", grant); end
      vec++; if ({busy, done, abort, err} !== 4'b0) begin
         miss++; $display("FAIL rst_flags got %b want 0000", {busy, done, abort, err});
      end
      reset = 1'b0;
      tick;
      vec++; if (busy !== 1'b0) begin miss++; $display("FAIL rst_idle_busy got %b want 0", busy); end
   endtask

   task automatic test_single_burst;
      do_reset;
      set_cfg(0, 3, 4);
      req = 4'b0001;
      wait_done(100);
      vec++; if (dcyc !== 15) begin miss++; $display("FAIL sb_done_cyc got %0d want 15", dcyc); end
      vec++; if (gcnt !== 14) begin miss++; $display("FAIL sb_grant_cycles got %0d want 14", gcnt); end
      vec++; if (rcnt !== 13) begin miss++; $display("FAIL sb_run_cycles got %0d want 13", rcnt); end
      vec++; if (togs !== 4) begin miss++; $display("FAIL sb_toggles got %0d want 4", togs); end
      for (int k = 1; k < 4; k++) begin
         vec++;
         if (tc[k] - tc[k-1] !== 3) begin
            miss++; $display("FAIL sb_tog_gap%0d got %0d want 3", k, tc[k] - tc[k-1]);
         end
      end
      vec++; if (dabort !== 1'b0) begin miss++; $display("FAIL sb_abort got %b want 0", dabort); end
      vec++; if (dgrant !== 4'b0) begin miss++; $display("FAIL sb_grant_at_done got %b want 0000", dgrant); end
      req = '0;
      tick;
      vec++; if ({done, div_rst, busy} !== 3'b010) begin
         miss++; $display("FAIL sb_after got done/rst/busy %b want 010", {done, div_rst, busy});
      end
   endtask

   task automatic test_round_robin;
      logic [NR-1:0] exp_g [0:4];
      logic [NR-1:0] got [0:4];
      logic [NR-1:0] prevg;
      int n, mh;
      exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
      exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
      do_reset;
      for (int i = 0; i < NR; i++) set_cfg(i, 1, 2);
      req = 4'b1111;
      n = 0; mh = 0; prevg = '0;
      for (int c = 0; c < 150 && n < 5; c++) begin
         tick;
         if ($countones(grant) > 1) mh++;
         if (grant != '0 && prevg == '0) begin
            got[n] = grant;
            n++;
         end
         prevg = grant;
      end
      vec++; if (n !== 5) begin miss++; $display("FAIL rr_count got %0d want 5", n); end
      for (int k = 0; k < 5; k++) begin
         if (k < n) begin
            vec++;
            if (got[k] !== exp_g[k]) begin
               miss++; $display("FAIL rr_order%0d got %b want %b", k, got[k], exp_g[k]);
            end
         end
      end
      vec++; if (mh !== 0) begin miss++; $display("FAIL rr_onehot got %0d multi-hot cycles want 0", mh); end
      do_reset;
   endtask

   task automatic test_abort;
      do_reset;
      set_cfg(2, 10, 5);
      req = 4'b0100;
      for (int c = 0; c <= 8; c++) tick;
      vec++; if ({grant, done, div_rst} !== 6'b010000) begin
         miss++; $display("FAIL ab_run got grant/done/rst %b want 010000", {grant, done, div_rst});
      end
      req = '0;
      tick;
      vec++; if ({done, abort} !== 2'b11) begin
         miss++; $display("FAIL ab_release got done/abort %b want 11", {done, abort});
      end
      vec++; if ({grant, div_rst} !== 5'b00001) begin
         miss++; $display("FAIL ab_release got grant/rst %b want 00001", {grant, div_rst});
      end
      tick;
      vec++; if ({done, busy} !== 2'b00) begin
         miss++; $display("FAIL ab_idle got done/busy %b want 00", {done, busy});
      end
      set_cfg(1, 1, 1); set_cfg(3, 1, 1);
      req = 4'b1010;
      tick; tick;
      vec++; if (grant !== 4'b1000) begin miss++; $display("FAIL ab_pointer got %b want 1000", grant); end
      do_reset;
   endtask

   task automatic test_invalid;
      do_reset;
      set_cfg(1, 0, 5); set_cfg(3, 1, 1);
      req = 4'b1010;
      tick;
      vec++; if ({busy, err} !== 2'b10) begin
         miss++; $display("FAIL inv_arb got busy/err %b want 10", {busy, err});
      end
      tick;
      vec++; if ({err, grant, div_rst, busy} !== 7'b1000010) begin
         miss++; $display("FAIL inv_n0 got err/grant/rst/busy %b want 1000010", {err, grant, div_rst, busy});
      end
      tick;
      vec++; if (err !== 1'b0) begin miss++; $display("FAIL inv_err_width got %b want 0", err); end
      tick;
      vec++; if (grant !== 4'b1000) begin miss++; $display("FAIL inv_next_winner got %b want 1000", grant); end
      wait_done(20);
      vec++; if (dcyc !== 2) begin miss++; $display("FAIL inv_r3_done got %0d want 2", dcyc); end
      req = '0;
      tick;
      set_cfg(3, 4, 0);
      req = 4'b1000;
      tick; tick;
      vec++; if ({err, grant, div_rst} !== 6'b100001) begin
         miss++; $display("FAIL inv_t0 got err/grant/rst %b want 100001", {err, grant, div_rst});
      end
      tick;
      req = '0;
      tick;
      vec++; if ({err, busy} !== 2'b00) begin
         miss++; $display("FAIL inv_drop got err/busy %b want 00", {err, busy});
      end
   endtask

   task automatic test_reset_mid_run;
      do_reset;
      set_cfg(0, 5, 5);
      req = 4'b0001;
      for (int c = 0; c < 6; c++) tick;
      vec++; if ({grant, div_rst} !== 5'b00010) begin
         miss++; $display("FAIL rm_run got grant/rst %b want 00010", {grant, div_rst});
      end
      #1 reset = 1'b1;
      #1;
      vec++; if ({grant, div_rst, busy, done} !== 7'b0000100) begin
         miss++; $display("FAIL rm_async got grant/rst/busy/done %b want 0000100", {grant, div_rst, busy, done});
      end
      tick; tick;
      vec++; if (done !== 1'b0) begin miss++; $display("FAIL rm_no_done got %b want 0", done); end
      set_cfg(0, 1, 1); set_cfg(1, 1, 1);
      req = 4'b0011;
      reset = 1'b0;
      tick; tick;
      vec++; if (grant !== 4'b0001) begin miss++; $display("FAIL rm_first_winner got %b want 0001", grant); end
      do_reset;
   endtask

   task automatic test_boundary;
      do_reset;
      set_cfg(0, 1, 1);
      req = 4'b0001;
      wait_done(20);
      vec++; if (dcyc !== 4) begin miss++; $display("FAIL bd_n1t1_done got %0d want 4", dcyc); end
      vec++; if (gcnt !== 3) begin miss++; $display("FAIL bd_n1t1_grant got %0d want 3", gcnt); end
      req = '0;
      tick;
      set_cfg(0, 255, 255);
      req = 4'b0001;
      wait_done(70000);
      vec++; if (dcyc !== 65028) begin miss++; $display("FAIL bd_max_done got %0d want 65028", dcyc); end
      vec++; if (rcnt !== 65026) begin miss++; $display("FAIL bd_max_run got %0d want 65026", rcnt); end
      vec++; if (gcnt !== 65027) begin miss++; $display("FAIL bd_max_grant got %0d want 65027", gcnt); end
      vec++; if (dabort !== 1'b0) begin miss++; $display("FAIL bd_max_abort got %b want 0", dabort); end
      vec++; if (div_n !== 8'd255) begin miss++; $display("FAIL bd_max_div_n got %0d want 255", div_n); end
      req = '0;
      tick;
      vec++; if (busy !== 1'b0) begin miss++; $display("FAIL bd_max_idle got %b want 0", busy); end
   endtask

   initial begin
      test_reset;
      test_single_burst;
      test_round_robin;
      test_abort;
      test_invalid;
      test_reset_mid_run;
      test_boundary;
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule

// File: doc/clkdiv_scheduler.md
# clkdiv_scheduler

Round-robin scheduler that shares one `frequency_divider` instance among `NUM_REQ` requesters. Each requester presents a divide ratio and a burst length in output toggles. The block grants the divider to one requester at a time, loads its ratio, holds the divider in reset while it is idle or being reconfigured, counts output toggles, and releases the divider when the burst completes or the requester aborts. It sits between requester logic and the divider's `N` and `reset` inputs, and takes the divider's `clk_out` back as `div_clk_in`.

## Interface
- `NUM_REQ`, default 4: number of requesters; range 2–8.
- `DIV_W`, default 8: width of the divide ratio and of the toggle count.

Ports:
- `clk`  in  1  system clock; the divider runs on the same clock.
- `reset`  in  1  asynchronous, active-high.
- `req`  in  NUM_REQ  per-requester request level; must be held until `done`.
- `req_div`  in  NUM_REQ*DIV_W  packed divide ratios; requester i occupies bits [i*DIV_W +: DIV_W].
- `req_tog`  in  NUM_REQ*DIV_W  packed burst lengths, in `clk_out` toggles.
- `div_clk_in`  in  1  divider `clk_out`, registered in the `clk` domain.
- `div_n`  out  DIV_W  drives divider `N`.
- `div_rst`  out  1  drives divider `reset`.
- `grant`  out  NUM_REQ  one-hot owner of the divider.
- `busy`  out  1  high whenever state is not IDLE.
- `done`  out  1  one-cycle pulse at the end of each granted burst.
- `abort`  out  1  qualifies `done`: the burst ended early because the request was dropped.
- `err`  out  1  one-cycle pulse when a winning configuration is rejected.

## Operation
States: IDLE, ARB, LOAD, RUN, RELEASE. All outputs are registered.

Reset values:
- State IDLE; `div_n`=0; `div_rst`=1.
- `grant`, `busy`, `done`, `abort`, `err` all 0.
- Toggle counter 0; last-grant pointer = NUM_REQ-1.

IDLE:
- `div_rst`=1.
- If `|req`, go to ARB.

ARB:
- Select the winner with round-robin priority. Search starts at (pointer+1) mod NUM_REQ and wraps.
- Latch the winner's index, `req_div` and `req_tog`.
- If the latched ratio is 0 or the toggle count is 0: pulse `err`, set pointer = winner, go to IDLE. No grant is issued.
- Otherwise go to LOAD.
- If `req` has dropped to all-zero by this cycle, return to IDLE with no `err`.

LOAD:
- `div_n` = latched ratio; `div_rst`=1; `grant[winner]`=1.
- Toggle counter cleared; edge-detect register `div_clk_q` forced to 0.
- Go to RUN.

RUN:
- `div_rst`=0; `grant` held.
- `tog_seen` = `div_clk_in` XOR `div_clk_q`. `div_clk_q` samples `div_clk_in` every cycle.
- Each `tog_seen` increments the counter.
- When `tog_seen` occurs and counter+1 equals the latched count, go to RELEASE with `abort`=0.
- If `req[winner]`=0 on any RUN cycle, go to RELEASE with `abort`=1. Abort wins over a simultaneous final toggle.

RELEASE:
- `div_rst`=1; `grant`=0.
- `done`=1 for this cycle; `abort` valid with `done`.
- Pointer = winner; go to IDLE.

Rules:
- Changes to `req_div` or `req_tog` after ARB are ignored until the next arbitration.
- Requests arriving during a burst wait; they are arbitrated on the next pass through IDLE→ARB.
- `div_n` holds its last value outside LOAD.
- `reset` mid-burst returns immediately to reset values: `div_rst`=1, `grant`=0, and no `done` pulse.

## Timing
- `req` rising before clock edge E: ARB at E, LOAD at E+1, RUN from E+2.
- The divider releases at the start of RUN and toggles `clk_out` every N cycles.
- For ratio N and count T, RUN lasts N·T+1 cycles.
- `done` is high for exactly one cycle, (N·T+3) cycles after the ARB edge.
- `grant` is high from LOAD through the last RUN cycle, N·T+2 cycles. It drops in the same cycle `done` rises.
- Back-to-back bursts leave a minimum gap of 2 cycles (IDLE, ARB) between RELEASE and the next LOAD.
- `div_rst` is low only in RUN, so the divider always restarts with counter=0 and `clk_out`=0.
- Rejected configuration: `err` asserts at the ARB edge +1, i.e. the cycle after ARB, alongside the return to IDLE.

## Test plan
- **Single burst.** After reset, `req`=0001, `req_div[0]`=3, `req_tog[0]`=4 → `grant`=0001 for 14 cycles, 4 `div_clk_in` toggles observed 3 cycles apart, `done`=1 / `abort`=0 for one cycle, `div_rst` returns to 1.
- **Round-robin fairness.** `req`=1111 held, all N=1, T=2 → grants issued in order 0001, 0010, 0100, 1000, 0001; `grant` is never more than one-hot.
- **Mid-burst abort.** `req[2]` with N=10, T=5; drop `req[2]` in the 7th RUN cycle → next cycle is RELEASE with `done`=1 and `abort`=1; grant pointer advances to 2.
- **Invalid configurations.** Requester 1 with N=0 → `err` pulse, no grant, `div_rst` stays 1. Requester 3 with T=0 → `err`. With `req`=1010, the next winner after requester 1's rejection is requester 3.
- **Reset mid-run.** Assert `reset` during RUN → `grant`=0, `div_rst`=1, `busy`=0, no `done`. After release, `req`=0011 → requester 0 wins first (pointer reset to NUM_REQ-1).
- **Boundary values.** N=255, T=255 → RUN lasts 65026 cycles and the counter does not wrap before `done`. N=1, T=1 → `done` appears 4 cycles after ARB.
